axis_frame_checker: RTL and testbench
=====================================

AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

Interface
REQ-001 SHALL have parameter: DATA_NUM, 1024, expected data beats per frame (>=2).
REQ-002 SHALL have parameter: CHECK_DATA, 1, when 1 compare each tdata to beat index modulo 256.
REQ-003 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: s_axis_tdata  in  8  stream data.
REQ-006 SHALL have port: s_axis_tvalid  in  1  beat valid.
REQ-007 SHALL have port: s_axis_tready  out  1  beat accept.
REQ-008 SHALL have port: s_axis_tuser  in  1  start of frame, first beat.
REQ-009 SHALL have port: s_axis_tlast  in  1  end of frame, last beat.
REQ-010 SHALL have port: frame_done  out  1  one-cycle pulse per closed frame.
REQ-011 SHALL have port: frame_ok  out  1  closed frame passed all checks, valid with frame_done.
REQ-012 SHALL have port: err_code  out  3  0 none, 1 short, 2 long, 3 data mismatch, 4 SOF mid-frame.
REQ-013 SHALL have port: last_len  out  32  beats accepted in closed frame.
REQ-014 SHALL have port: checksum  out  16  modulo-2^16 sum of bytes of closed frame.
REQ-015 SHALL have port: frame_cnt  out  16  closed frames, wraps.
REQ-016 SHALL have port: err_cnt  out  16  frames with err_code!=0, saturates at 16'hFFFF.
REQ-017 SHALL have port: drop_cnt  out  16  beats discarded in IDLE, saturates.

Function
REQ-018 SHALL define a beat as s_axis_tvalid & s_axis_tready high at clk rising edge; nothing else advances state.
REQ-019 SHALL implement states IDLE, RECV, DRAIN, REPORT.
REQ-020 SHALL in IDLE: beat with tuser=1 -> RECV, index=1, checksum seeded with tdata; tuser=1 with tlast=1 -> REPORT, err 1; beat with tuser=0 -> discard, drop_cnt+1.
REQ-021 SHALL in RECV: tlast at index<DATA_NUM-1 -> REPORT, err 1; tlast at index==DATA_NUM-1 -> REPORT, no length error; no tlast at index==DATA_NUM-1 -> DRAIN, err 2.
REQ-022 SHALL in DRAIN accept beats, add to len/checksum, until tlast -> REPORT keeping err 2.
REQ-023 SHALL, when tuser=1 during RECV or DRAIN, close current frame (err 4) and treat that beat as first beat of a new frame.
REQ-024 SHALL record only first error per frame; err 4 overrides any earlier code.
REQ-025 SHALL, with CHECK_DATA=1, flag err 3 when tdata != index[7:0] in RECV.
REQ-026 SHALL hold s_axis_tready high in IDLE, RECV, DRAIN; low for exactly one cycle in REPORT, then IDLE.
REQ-027 SHALL pulse frame_done one cycle after the closing beat, updating frame_ok, err_code, last_len, checksum, frame_cnt, err_cnt in same cycle; hold them until next close.
REQ-028 SHALL keep 32-bit beat index; index never wraps within DATA_NUM+2^31.

Reset
REQ-029 SHALL on reset_n low asynchronously enter IDLE, s_axis_tready=0, frame_done=0, frame_ok=0, err_code=0, all counts/len/checksum=0.
REQ-030 SHALL raise s_axis_tready first clock after reset_n deasserts; partial frame at reset is discarded, not counted.

Verification
REQ-031 SHALL cover: DATA_NUM=16, frame tdata 0..15, tuser on beat 0, tlast on beat 15 -> frame_done, frame_ok=1, err_code=0, last_len=16, checksum=120, frame_cnt=1.
REQ-032 SHALL cover: tlast on beat 9 -> err_code=1, last_len=10, err_cnt=1, tready low one cycle after.
REQ-033 SHALL cover: tlast on beat 19 -> err_code=2, last_len=20.
REQ-034 SHALL cover: 3 beats without tuser then good frame -> drop_cnt=3, frame_ok=1.
REQ-035 SHALL cover: tuser on beat 5 of frame -> err_code=4, last_len=5, following frame completes ok with frame_cnt=2.
REQ-036 SHALL cover: random tvalid gaps and reset_n pulsed mid-frame -> outputs zero immediately, next frame ok=1, frame_cnt=1.

Source files
------------

// File: rtl/axis_frame_checker.sv
// axis_frame_checker
//   Checks 8-bit AXI-Stream frames against an expected length and, optionally,
//   an incrementing data pattern. Each closed frame is reported with a
//   one-cycle frame_done pulse, and the per-frame results are held until the
//   next frame closes.
//
// Handshake: a beat is s_axis_tvalid & s_axis_tready at a rising clk edge.
//   Nothing advances on any other cycle. s_axis_tready is registered and stays
//   low for exactly one cycle (REPORT) after each closing beat.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   s_axis_tdata/tvalid/tready   stream beat
//   s_axis_tuser / s_axis_tlast  start / end of frame markers
//   frame_done                   one-cycle pulse per closed frame
//   frame_ok, err_code           result of the closed frame
//                                (err 0 none, 1 short, 2 long, 3 data, 4 SOF mid-frame)
//   last_len, checksum           beats and byte sum of the closed frame
//   frame_cnt                    closed frames (wraps)
//   err_cnt                      frames with err_code != 0 (saturates)
//   drop_cnt                     beats discarded in IDLE (saturates)
//   fsm_state                    debug view of the FSM state
module axis_frame_checker #(
    parameter int unsigned DATA_NUM   = 1024,
    parameter bit          CHECK_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [2:0]  err_code,
    output logic [31:0] last_len,
    output logic [15:0] checksum,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [2:0]  ERR_NONE  = 3'd0;
    localparam logic [2:0]  ERR_SHORT = 3'd1;
    localparam logic [2:0]  ERR_LONG  = 3'd2;
    localparam logic [2:0]  ERR_DATA  = 3'd3;
    localparam logic [2:0]  ERR_SOF   = 3'd4;
    localparam logic [31:0] LAST_IDX  = 32'(DATA_NUM - 1);

    state_t      state_q;
    logic [31:0] idx_q;        // beats accepted so far in the open frame
    logic [15:0] sum_q;
    logic [2:0]  err_q;        // first error seen in the open frame
    logic        pend_q;       // a SOF beat closed the old frame and opened a new one
    logic        pend_last_q;  // ... and that SOF beat also carried tlast

    logic        beat;
    logic [31:0] len_nx;
    logic [15:0] sum_nx;
    logic [2:0]  rx_err;
    logic        close_en;
    logic [2:0]  close_err;
    logic [31:0] close_len;
    logic [15:0] close_sum;

    assign fsm_state = state_q;
    assign beat      = s_axis_tvalid && s_axis_tready;
    assign len_nx    = idx_q + 32'd1;
    assign sum_nx    = sum_q + {8'h00, s_axis_tdata};

    // Error for a non-SOF beat in RECV; an earlier error always wins.
    always_comb begin
        rx_err = err_q;
        if (err_q == ERR_NONE) begin
            if (CHECK_DATA && (s_axis_tdata != idx_q[7:0]))
                rx_err = ERR_DATA;
            else if (s_axis_tlast && (idx_q < LAST_IDX))
                rx_err = ERR_SHORT;
            else if (!s_axis_tlast && (idx_q == LAST_IDX))
                rx_err = ERR_LONG;
        end
    end

    // What to report when a frame closes this cycle.
    always_comb begin
        close_en  = 1'b0;
        close_err = ERR_NONE;
        close_len = 32'd0;
        close_sum = 16'd0;
        case (state_q)
            S_IDLE: begin
                if (beat && s_axis_tuser && s_axis_tlast) begin
                    close_en  = 1'b1;
                    close_err = ERR_SHORT;
                    close_len = 32'd1;
                    close_sum = {8'h00, s_axis_tdata};
                end
            end
            S_RECV, S_DRAIN: begin
                if (beat && s_axis_tuser) begin
                    // The SOF beat belongs to the next frame, not this one.
                    close_en  = 1'b1;
                    close_err = ERR_SOF;
                    close_len = idx_q;
                    close_sum = sum_q;
                end else if (beat && s_axis_tlast) begin
                    close_en  = 1'b1;
                    close_err = (state_q == S_RECV) ? rx_err : err_q;
                    close_len = len_nx;
                    close_sum = sum_nx;
                end
            end
            S_REPORT: begin
                // Pending one-beat frame opened by a SOF that also had tlast.
                if (pend_q && pend_last_q) begin
                    close_en  = 1'b1;
                    close_err = ERR_SHORT;
                    close_len = idx_q;
                    close_sum = sum_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 32'd0;
            sum_q         <= 16'd0;
            err_q         <= ERR_NONE;
            pend_q        <= 1'b0;
            pend_last_q   <= 1'b0;
            s_axis_tready <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= ERR_NONE;
            last_len      <= 32'd0;
            checksum      <= 16'd0;
            frame_cnt     <= 16'd0;
            err_cnt       <= 16'd0;
            drop_cnt      <= 16'd0;
        end else begin
            frame_done    <= close_en;
            s_axis_tready <= 1'b1;
            if (close_en) begin
                frame_ok  <= (close_err == ERR_NONE);
                err_code  <= close_err;
                last_len  <= close_len;
                checksum  <= close_sum;
                frame_cnt <= frame_cnt + 16'd1;
                if ((close_err != ERR_NONE) && (err_cnt != 16'hFFFF))
                    err_cnt <= err_cnt + 16'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        if (s_axis_tuser) begin
                            idx_q <= 32'd1;
                            sum_q <= {8'h00, s_axis_tdata};
                            err_q <= ERR_NONE;
                            if (s_axis_tlast) begin
                                state_q       <= S_REPORT;
                                s_axis_tready <= 1'b0;
                            end else begin
                                state_q <= S_RECV;
                            end
                        end else if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end
                end
                S_RECV, S_DRAIN: begin
                    if (beat) begin
                        if (s_axis_tuser) begin
                            idx_q         <= 32'd1;
                            sum_q         <= {8'h00, s_axis_tdata};
                            err_q         <= ERR_NONE;
                            pend_q        <= 1'b1;
                            pend_last_q   <= s_axis_tlast;
                            state_q       <= S_REPORT;
                            s_axis_tready <= 1'b0;
                        end else begin
                            idx_q <= len_nx;
                            sum_q <= sum_nx;
                            if (state_q == S_RECV)
                                err_q <= rx_err;
                            if (s_axis_tlast) begin
                                state_q       <= S_REPORT;
                                s_axis_tready <= 1'b0;
                            end else if (state_q == S_RECV && idx_q == LAST_IDX) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end
                S_REPORT: begin
                    if (pend_q) begin
                        if (pend_last_q) begin
                            // Report the pending one-beat frame from here.
                            pend_last_q   <= 1'b0;
                            pend_q        <= 1'b0;
                            s_axis_tready <= 1'b0;
                        end else begin
                            pend_q  <= 1'b0;
                            state_q <= S_RECV;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Testbench for axis_frame_checker with DATA_NUM=16, CHECK_DATA=1.
module tb_axis_frame_checker;
  localparam int DN = 16;
  localparam int W  = 84;  // {ok, err, len, sum, frame_cnt, err_cnt}

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        frame_done;
  logic        frame_ok;
  logic [2:0]  err_code;
  logic [31:0] last_len;
  logic [15:0] checksum;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] fc_m = 16'd0;
  logic [15:0] ec_m = 16'd0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  axis_frame_checker #(.DATA_NUM(DN), .CHECK_DATA(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .frame_done(frame_done),
    .frame_ok(frame_ok), .err_code(err_code), .last_len(last_len),
    .checksum(checksum), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .drop_cnt(drop_cnt), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n && frame_done)
      obs_q.push_back({frame_ok, err_code, last_len, checksum, frame_cnt, err_cnt});

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    fc_m = 16'd0;
    ec_m = 16'd0;
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    guard = 0;
    while (!s_axis_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL tready_timeout: tready=%0b required 1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  // Beats with data = index, tuser on beat 0, tlast on beat n-1.
  task automatic send_frame(input int n, input int max_gap);
    for (int i = 0; i < n; i++)
      send_beat(8'(i), i == 0, i == n - 1, $urandom_range(0, max_gap));
  endtask

  // Scoreboard model: expected report for the next closed frame.
  task automatic push_exp(input logic [2:0] e, input logic [31:0] len, input logic [15:0] sum);
    fc_m = fc_m + 16'd1;
    if (e != 3'd0 && ec_m != 16'hFFFF) ec_m = ec_m + 16'd1;
    exp_q.push_back({e == 3'd0, e, len, sum, fc_m, ec_m});
  endtask

  task automatic wait_obs(input int n);
    int g;
    g = 0;
    while (obs_q.size() < n && g < 200) begin
      @(negedge clk);
      g++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W+16+1:0] all_o;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    all_o = {s_axis_tready, frame_done, frame_ok, err_code, last_len, checksum, frame_cnt, err_cnt, drop_cnt};
    checks++;
    if (all_o !== '0) begin
      failures++;
      $display("FAIL reset_state: outputs=%h required 0", all_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready: got %0b required 1", s_axis_tready);
    end
  endtask

  task automatic test_good();
    logic [W-1:0] e, g;
    send_frame(DN, 0);
    push_exp(3'd0, 32'd16, 16'd120);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL good_frame: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL good_frame: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_short();
    logic [W-1:0] e, g;
    send_frame(10, 1);
    push_exp(3'd1, 32'd10, 16'd45);
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL short_tready_low: got %0b required 0", s_axis_tready);
    end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL short_tready_back: got %0b required 1", s_axis_tready);
    end
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL short_frame: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL short_frame: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_long();
    logic [W-1:0] e, g;
    send_frame(20, 1);
    push_exp(3'd2, 32'd20, 16'd190);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL long_frame: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL long_frame: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] e, g;
    for (int i = 0; i < 3; i++)
      send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL drop_cnt: got %0d required 3", drop_cnt);
    end
    send_frame(DN, 0);
    push_exp(3'd0, 32'd16, 16'd120);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL drop_then_good: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL drop_then_good: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] e, g;
    for (int i = 0; i < DN; i++)
      send_beat((i == 7) ? 8'hAA : 8'(i), i == 0, i == DN - 1, 0);
    push_exp(3'd3, 32'd16, 16'd283);  // 120 - 7 + 170
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL data_mismatch: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL data_mismatch: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] e, g;
    send_beat(8'h55, 1'b1, 1'b1, 0);
    push_exp(3'd1, 32'd1, 16'h0055);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL single_beat: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL single_beat: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_sof_mid();
    logic [W-1:0] e, g;
    do_reset();
    for (int i = 0; i < 5; i++)
      send_beat(8'(i), i == 0, 1'b0, 0);
    send_frame(DN, 0);
    push_exp(3'd4, 32'd5, 16'd10);
    push_exp(3'd0, 32'd16, 16'd120);
    wait_obs(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL sof_mid: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL sof_mid: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    send_frame(DN, 0);
    push_exp(3'd0, 32'd16, 16'd120);
    send_frame(DN, 0);
    push_exp(3'd0, 32'd16, 16'd120);
    wait_obs(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL back_to_back: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL back_to_back: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e, g;
    logic [W+16+1:0] all_o;
    for (int i = 0; i < 7; i++)
      send_beat(8'(i), i == 0, 1'b0, $urandom_range(0, 3));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    all_o = {s_axis_tready, frame_done, frame_ok, err_code, last_len, checksum, frame_cnt, err_cnt, drop_cnt};
    checks++;
    if (all_o !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: outputs=%h required 0", all_o);
    end
    exp_q.delete();
    obs_q.delete();
    fc_m = 16'd0;
    ec_m = 16'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_frame(DN, 3);
    push_exp(3'd0, 32'd16, 16'd120);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL reset_mid_next_frame: no frame_done, required %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL reset_mid_next_frame: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_drop_cnt: got %0d required 0", drop_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good();
    test_short();
    test_long();
    test_drop();
    test_mismatch();
    test_single();
    test_sof_mid();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
